// File: rtl/state_transitions.sv
// Micro vending machine controller: one-hot FSM for selection, payment, cancel and change,
// with money accumulation and cart pricing. All outputs are registered.
module state_transitions (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sys_Goods,
    input  logic       sys_Confirm,
    input  logic       sys_Change,
    input  logic       sys_Cancel,
    input  logic       in_money_one,
    input  logic       in_money_five,
    input  logic       in_money_ten,
    input  logic       in_money_twenty,
    input  logic       in_money_fifty,
    input  logic [2:0] type_SW_high,
    input  logic [2:0] type_SW_low,
    input  logic [1:0] num_SW,
    output logic [7:0] input_money,
    output logic [6:0] need_money,
    output logic [7:0] change_money,
    output logic [5:0] state_out
);
    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        SELECT = 6'b000010,
        PAY    = 6'b000100,
        CHANGE = 6'b001000,
        DONE   = 6'b010000,
        CANCEL = 6'b100000
    } state_t;

    localparam int B_GOODS   = 0;
    localparam int B_CONFIRM = 1;
    localparam int B_CHANGE  = 2;
    localparam int B_CANCEL  = 3;
    localparam int B_ONE     = 4;
    localparam int B_FIVE    = 5;
    localparam int B_TEN     = 6;
    localparam int B_TWENTY  = 7;
    localparam int B_FIFTY   = 8;

    state_t     state;
    logic [8:0] now;
    logic [8:0] prev;
    logic [8:0] rise;
    logic [4:0] unit_price;
    logic [5:0] subtotal;
    logic [5:0] line_a;
    logic [6:0] cart_total;
    logic [6:0] coin_sum;
    logic [8:0] paid_sum;
    logic [7:0] paid_next;

    assign now = {in_money_fifty, in_money_twenty, in_money_ten, in_money_five, in_money_one,
                  sys_Cancel, sys_Change, sys_Confirm, sys_Goods};
    assign rise = now & ~prev;
    assign state_out = state;

    always_comb begin
        unit_price = 5'd0;
        if (type_SW_high != 3'd0 && type_SW_low != 3'd0)
            unit_price = {1'b0, type_SW_high, 1'b0} + {2'b00, type_SW_low};
        subtotal   = {1'b0, unit_price} * {4'b0000, num_SW};
        cart_total = {1'b0, line_a} + {1'b0, subtotal};
        coin_sum   = (rise[B_ONE]    ? 7'd1  : 7'd0) + (rise[B_FIVE]   ? 7'd5  : 7'd0)
                   + (rise[B_TEN]    ? 7'd10 : 7'd0) + (rise[B_TWENTY] ? 7'd20 : 7'd0)
                   + (rise[B_FIFTY]  ? 7'd50 : 7'd0);
        paid_sum   = {1'b0, input_money} + {2'b00, coin_sum};
        // A coin edge that would overflow the 8-bit total is refused as a whole.
        paid_next  = paid_sum[8] ? input_money : paid_sum[7:0];
    end

    always_ff @(posedge sys_clk) begin
        prev <= now;
        if (sys_rst_n) begin
            state        <= IDLE;
            input_money  <= 8'd0;
            need_money   <= 7'd0;
            change_money <= 8'd0;
            line_a       <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise[B_CONFIRM])
                        state <= SELECT;
                end
                SELECT: begin
                    need_money <= cart_total;
                    if (rise[B_CANCEL])
                        state <= CANCEL;
                    else if (rise[B_CONFIRM]) begin
                        if (cart_total != 7'd0)
                            state <= PAY;
                    end else if (rise[B_GOODS]) begin
                        if (line_a == 6'd0 && subtotal != 6'd0)
                            line_a <= subtotal;
                    end
                end
                PAY: begin
                    input_money <= paid_next;
                    if (rise[B_CANCEL])
                        state <= CANCEL;
                    else if (rise[B_CONFIRM] && paid_next >= {1'b0, need_money}) begin
                        state        <= CHANGE;
                        change_money <= paid_next - {1'b0, need_money};
                    end
                end
                CANCEL: begin
                    if (rise[B_CONFIRM]) begin
                        state        <= CHANGE;
                        change_money <= input_money;
                        need_money   <= 7'd0;
                    end
                end
                CHANGE: begin
                    if (rise[B_CHANGE]) begin
                        state        <= DONE;
                        change_money <= 8'd0;
                    end
                end
                DONE: begin
                    if (rise[B_CHANGE] || rise[B_CONFIRM]) begin
                        state       <= IDLE;
                        input_money <= 8'd0;
                        need_money  <= 7'd0;
                        line_a      <= 6'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_state_transitions.sv
// Bench for the vending controller: directed scenarios plus random button/coin traffic,
// all checked cycle by cycle against a behavioural model through an expected queue.
module tb_state_transitions;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       sys_Goods = 1'b0, sys_Confirm = 1'b0, sys_Change = 1'b0, sys_Cancel = 1'b0;
    logic       in_money_one = 1'b0, in_money_five = 1'b0, in_money_ten = 1'b0;
    logic       in_money_twenty = 1'b0, in_money_fifty = 1'b0;
    logic [2:0] type_SW_high = 3'd0, type_SW_low = 3'd0;
    logic [1:0] num_SW = 2'd0;
    logic [7:0] input_money;
    logic [6:0] need_money;
    logic [7:0] change_money;
    logic [5:0] state_out;

    localparam logic [8:0] GOODS = 9'h001, CONF = 9'h002, CHG = 9'h004, CANCEL = 9'h008;
    localparam logic [8:0] ONE = 9'h010, FIVE = 9'h020, TEN = 9'h040, TWENTY = 9'h080, FIFTY = 9'h100;
    localparam int PH_IDLE = 0, PH_SELECT = 1, PH_PAY = 2, PH_CHANGE = 3, PH_DONE = 4, PH_CANCEL = 5;

    typedef struct packed {
        logic [5:0] st;
        logic [7:0] paid;
        logic [6:0] need;
        logic [7:0] chg;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // behavioural model state
    int   m_ph = PH_IDLE, m_paid = 0, m_need = 0, m_chg = 0, m_line = 0;
    logic [8:0] m_prev = 9'h000;

    state_transitions dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .sys_Goods(sys_Goods), .sys_Confirm(sys_Confirm), .sys_Change(sys_Change),
        .sys_Cancel(sys_Cancel),
        .in_money_one(in_money_one), .in_money_five(in_money_five), .in_money_ten(in_money_ten),
        .in_money_twenty(in_money_twenty), .in_money_fifty(in_money_fifty),
        .type_SW_high(type_SW_high), .type_SW_low(type_SW_low), .num_SW(num_SW),
        .input_money(input_money), .need_money(need_money), .change_money(change_money),
        .state_out(state_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected observation per clock edge, compared just after the edge.
    always @(posedge sys_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("state_out", {26'd0, state_out}, {26'd0, mon_e.st});
            check("input_money", {24'd0, input_money}, {24'd0, mon_e.paid});
            check("need_money", {25'd0, need_money}, {25'd0, mon_e.need});
            check("change_money", {24'd0, change_money}, {24'd0, mon_e.chg});
        end
    end

    task automatic model_step();
        logic [8:0] lv, e;
        int price, sub, coins;
        lv = {in_money_fifty, in_money_twenty, in_money_ten, in_money_five, in_money_one,
              sys_Cancel, sys_Change, sys_Confirm, sys_Goods};
        e = lv & ~m_prev;
        m_prev = lv;
        price = (type_SW_high != 0 && type_SW_low != 0) ? 2 * int'(type_SW_high) + int'(type_SW_low) : 0;
        sub = price * int'(num_SW);
        coins = ((e & ONE) != 0 ? 1 : 0) + ((e & FIVE) != 0 ? 5 : 0) + ((e & TEN) != 0 ? 10 : 0)
              + ((e & TWENTY) != 0 ? 20 : 0) + ((e & FIFTY) != 0 ? 50 : 0);
        if (sys_rst_n) begin
            m_ph = PH_IDLE; m_paid = 0; m_need = 0; m_chg = 0; m_line = 0;
        end else if (m_ph == PH_IDLE) begin
            if ((e & CONF) != 0) m_ph = PH_SELECT;
        end else if (m_ph == PH_SELECT) begin
            m_need = m_line + sub;
            if ((e & CANCEL) != 0) m_ph = PH_CANCEL;
            else if ((e & CONF) != 0) begin
                if (m_need > 0) m_ph = PH_PAY;
            end else if ((e & GOODS) != 0 && m_line == 0 && sub > 0) m_line = sub;
        end else if (m_ph == PH_PAY) begin
            if (m_paid + coins <= 255) m_paid = m_paid + coins;
            if ((e & CANCEL) != 0) m_ph = PH_CANCEL;
            else if ((e & CONF) != 0 && m_paid >= m_need) begin
                m_ph = PH_CHANGE; m_chg = m_paid - m_need;
            end
        end else if (m_ph == PH_CANCEL) begin
            if ((e & CONF) != 0) begin
                m_ph = PH_CHANGE; m_chg = m_paid; m_need = 0;
            end
        end else if (m_ph == PH_CHANGE) begin
            if ((e & CHG) != 0) begin
                m_ph = PH_DONE; m_chg = 0;
            end
        end else begin
            if ((e & (CHG | CONF)) != 0) begin
                m_ph = PH_IDLE; m_paid = 0; m_need = 0; m_line = 0;
            end
        end
        exp_q.push_back({6'(1 << m_ph), 8'(m_paid), 7'(m_need), 8'(m_chg)});
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        model_step();
        @(negedge sys_clk);
    endtask

    task automatic set_in(input logic [8:0] v);
        sys_Goods = v[0]; sys_Confirm = v[1]; sys_Change = v[2]; sys_Cancel = v[3];
        in_money_one = v[4]; in_money_five = v[5]; in_money_ten = v[6];
        in_money_twenty = v[7]; in_money_fifty = v[8];
    endtask

    task automatic pulse(input logic [8:0] v);
        set_in(v); tick();
        set_in(9'h000); tick();
    endtask

    task automatic set_sw(input int h, input int l, input int n);
        type_SW_high = 3'(h); type_SW_low = 3'(l); num_SW = 2'(n);
    endtask

    task automatic order24();
        pulse(CONF);
        set_sw(2, 3, 3); tick();
        pulse(GOODS);
        set_sw(1, 1, 1); tick();
        pulse(CONF);
    endtask

    initial begin
        int c;
        logic [8:0] v;
        @(negedge sys_clk);
        // reset
        sys_rst_n = 1'b1; tick();
        sys_rst_n = 1'b0; tick();
        check("rst_state", {26'd0, state_out}, 32'd1);
        check("rst_money", {8'd0, input_money, 1'b0, need_money, change_money}, 32'd0);

        // order of 21 + 3 and full payment
        order24();
        check("t2_state", {26'd0, state_out}, 32'd4);
        check("t2_need", {25'd0, need_money}, 32'd24);
        pulse(ONE); pulse(FIVE); pulse(TEN); pulse(TWENTY); pulse(FIFTY);
        check("t3_paid", {24'd0, input_money}, 32'd86);
        pulse(CONF);
        check("t3_state_change", {26'd0, state_out}, 32'd8);
        check("t3_change", {24'd0, change_money}, 32'd62);
        pulse(CHG);
        check("t3_state_done", {26'd0, state_out}, 32'd16);
        check("t3_change_paid", {24'd0, change_money}, 32'd0);
        pulse(CHG);
        pulse(CHG);
        check("t3_idle", {26'd0, state_out}, 32'd1);
        check("t3_cleared", {8'd0, input_money, 1'b0, need_money, change_money}, 32'd0);

        // cancel with full refund
        pulse(CONF);
        set_sw(2, 1, 1); tick();
        pulse(CONF);
        check("t4_need", {25'd0, need_money}, 32'd5);
        pulse(FIFTY);
        pulse(CANCEL);
        check("t4_cancel", {26'd0, state_out}, 32'd32);
        pulse(CONF);
        check("t4_refund", {24'd0, change_money}, 32'd50);
        check("t4_need_zero", {25'd0, need_money}, 32'd0);
        pulse(CHG); pulse(CHG);
        check("t4_idle", {26'd0, state_out}, 32'd1);

        // underpayment and a held coin
        order24();
        pulse(TWENTY);
        pulse(CONF);
        check("t5_stay_pay", {26'd0, state_out}, 32'd4);
        set_in(ONE);
        repeat (5) tick();
        set_in(9'h000); tick();
        check("t5_held_coin", {24'd0, input_money}, 32'd21);
        pulse(FIVE);
        pulse(CONF);
        check("t5_change", {24'd0, change_money}, 32'd2);
        pulse(CHG); pulse(CHG);

        // overflow rejection, then Goods+Cancel together in SELECT
        order24();
        repeat (5) pulse(FIFTY);
        pulse(TEN);
        check("t6_reject", {24'd0, input_money}, 32'd250);
        pulse(CANCEL); pulse(CONF);
        check("t6_refund", {24'd0, change_money}, 32'd250);
        pulse(CHG); pulse(CHG);
        pulse(CONF);
        set_sw(1, 1, 1); tick();
        pulse(GOODS | CANCEL);
        check("t6_cancel_prio", {26'd0, state_out}, 32'd32);
        pulse(CONF); pulse(CHG); pulse(CHG);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            v = 9'h000;
            sys_rst_n = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0)
                set_sw($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            case ($urandom_range(0, 11))
                0: v = GOODS;
                1, 2: v = CONF;
                3: v = CHG;
                4: if ($urandom_range(0, 3) == 0) v = CANCEL;
                5, 6, 7: begin
                    c = $urandom_range(1, 31);
                    v = 9'(c) << 4;
                end
                default: v = 9'h000;
            endcase
            set_in(v);
            tick();
        end
        set_in(9'h000);
        sys_rst_n = 1'b1; tick();
        sys_rst_n = 1'b0; tick();
        repeat (3) @(negedge sys_clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
